// File: rtl/datapath_pkg.sv
// ============================================================================
// datapath_pkg : shared width, ALU opcodes and register reset values
// Rev 1.0
// ============================================================================
`default_nettype none

package datapath_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int NUM_REGS       = 4;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_NOT  = 3'b101;
    localparam logic [2:0] OP_SLT  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    // Register n powers up holding the value n.
    function automatic int unsigned reset_value(input int unsigned idx);
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_unit.sv
// ============================================================================
// alu_unit : combinational 8-function unsigned ALU, no flags
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_unit
    import datapath_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        op,
    output logic [DATA_W-1:0] result
);

    always_comb begin
        result = a;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_XOR:  result = a ^ b;
            OP_OR:   result = a | b;
            OP_NOT:  result = ~a;
            OP_SLT:  result = DATA_W'(a < b);
            OP_PASS: result = a;
            default: result = a;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/datapath.sv
// ============================================================================
// datapath : 4-entry register file with two async read ports feeding the ALU
// Rev 1.0
// ============================================================================
`default_nettype none

module datapath
    import datapath_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        srcReg1Addr,
    input  logic [1:0]        srcReg2Addr,
    input  logic [1:0]        destRegAddr,
    input  logic [2:0]        aluOp,
    input  logic              regWrite,
    output logic [DATA_W-1:0] aluResult
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;

    // No bypass: operands always come from the registered state.
    assign op_a = regs_q[srcReg1Addr];
    assign op_b = regs_q[srcReg2Addr];

    alu_unit #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a      (op_a),
        .b      (op_b),
        .op     (aluOp),
        .result (aluResult)
    );

    always_comb begin
        regs_d = regs_q;
        if (regWrite) begin
            regs_d[destRegAddr] = aluResult;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= DATA_W'(reset_value(i));
            end
        end else begin
            regs_q <= regs_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_datapath.sv
// ============================================================================
// tb_datapath : directed self-checking bench for datapath
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_datapath;

    logic       clk;
    logic       reset;
    logic [1:0] srcReg1Addr;
    logic [1:0] srcReg2Addr;
    logic [1:0] destRegAddr;
    logic [2:0] aluOp;
    logic       regWrite;
    logic [7:0] aluResult;

    int n_checks = 0;
    int n_pass   = 0;

    datapath #(.DATA_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .srcReg1Addr (srcReg1Addr),
        .srcReg2Addr (srcReg2Addr),
        .destRegAddr (destRegAddr),
        .aluOp       (aluOp),
        .regWrite    (regWrite),
        .aluResult   (aluResult)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Observe a register through the PASS function of the ALU.
    task automatic read_reg(input int idx, output logic [7:0] v);
        regWrite    = 1'b0;
        aluOp       = 3'b111;
        srcReg1Addr = 2'(idx);
        #1;
        v = aluResult;
    endtask

    task automatic do_write(input logic [1:0] d, input logic [1:0] s1,
                            input logic [1:0] s2, input logic [2:0] op);
        @(negedge clk);
        destRegAddr = d;
        srcReg1Addr = s1;
        srcReg2Addr = s2;
        aluOp       = op;
        regWrite    = 1'b1;
        @(posedge clk);
        #1;
        regWrite    = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        #10;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        reset       = 1'b0;
        regWrite    = 1'b0;
        srcReg1Addr = 2'd0;
        srcReg2Addr = 2'd0;
        destRegAddr = 2'd0;
        aluOp       = 3'b000;
        // Writes must be ignored while reset is held low.
        #2;
        destRegAddr = 2'd0;
        srcReg1Addr = 2'd1;
        srcReg2Addr = 2'd2;
        regWrite    = 1'b1;
        #10;
        @(negedge clk);
        regWrite = 1'b0;
        reset    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            read_reg(i, v);
            n_checks++;
            if (v !== 8'(i)) $display("FAIL reset_R%0d: got %0d expected %0d", i, v, i);
            else n_pass++;
        end
        srcReg1Addr = 2'd1;
        srcReg2Addr = 2'd2;
        aluOp       = 3'b000;
        #1;
        n_checks++;
        if (aluResult !== 8'd3) $display("FAIL reset_add: got %0d expected 3", aluResult);
        else n_pass++;
    endtask

    task automatic test_sequence();
        logic [7:0] v;
        logic [7:0] exp_final [4];
        exp_final = '{8'd3, 8'd2, 8'd1, 8'd1};
        do_write(2'd0, 2'd1, 2'd2, 3'b000);
        read_reg(0, v);
        n_checks++;
        if (v !== 8'd3) $display("FAIL seq_add: R0 got %0d expected 3", v);
        else n_pass++;
        do_write(2'd1, 2'd2, 2'd3, 3'b010);
        read_reg(1, v);
        n_checks++;
        if (v !== 8'd2) $display("FAIL seq_and: R1 got %0d expected 2", v);
        else n_pass++;
        do_write(2'd3, 2'd2, 2'd0, 3'b011);
        read_reg(3, v);
        n_checks++;
        if (v !== 8'd1) $display("FAIL seq_xor: R3 got %0d expected 1", v);
        else n_pass++;
        do_write(2'd2, 2'd1, 2'd3, 3'b001);
        for (int i = 0; i < 4; i++) begin
            read_reg(i, v);
            n_checks++;
            if (v !== exp_final[i])
                $display("FAIL seq_final_R%0d: got %0d expected %0d", i, v, exp_final[i]);
            else n_pass++;
        end
    endtask

    task automatic test_op_sweep();
        logic [7:0] exp_res [8];
        exp_res = '{8'd5, 8'hFF, 8'd2, 8'd1, 8'd3, 8'hFD, 8'd1, 8'd2};
        apply_reset();
        regWrite    = 1'b0;
        srcReg1Addr = 2'd2;
        srcReg2Addr = 2'd3;
        for (int op = 0; op < 8; op++) begin
            aluOp = 3'(op);
            #1;
            n_checks++;
            if (aluResult !== exp_res[op])
                $display("FAIL op_%0d: got 0x%02h expected 0x%02h", op, aluResult, exp_res[op]);
            else n_pass++;
        end
    endtask

    task automatic test_write_enable();
        logic [7:0] v;
        @(negedge clk);
        regWrite    = 1'b0;
        destRegAddr = 2'd0;
        srcReg1Addr = 2'd1;
        srcReg2Addr = 2'd2;
        aluOp       = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        read_reg(0, v);
        n_checks++;
        if (v !== 8'd0) $display("FAIL wen_hold: R0 got %0d expected 0", v);
        else n_pass++;
    endtask

    task automatic test_read_during_write();
        logic [7:0] v;
        @(negedge clk);
        destRegAddr = 2'd1;
        srcReg1Addr = 2'd1;
        srcReg2Addr = 2'd1;
        aluOp       = 3'b000;
        regWrite    = 1'b1;
        #1;
        n_checks++;
        if (aluResult !== 8'd2) $display("FAIL rdw_before: got %0d expected 2", aluResult);
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if (aluResult !== 8'd4) $display("FAIL rdw_after: got %0d expected 4", aluResult);
        else n_pass++;
        regWrite = 1'b0;
        read_reg(1, v);
        n_checks++;
        if (v !== 8'd2) $display("FAIL rdw_stored: R1 got %0d expected 2", v);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        logic [7:0] v;
        apply_reset();
        do_write(2'd0, 2'd1, 2'd2, 3'b000);
        do_write(2'd3, 2'd3, 2'd3, 3'b000);
        @(negedge clk);
        srcReg1Addr = 2'd0;
        aluOp       = 3'b111;
        #1;
        n_checks++;
        if (aluResult !== 8'd3) $display("FAIL async_pre: R0 got %0d expected 3", aluResult);
        else n_pass++;
        // Pending write to R3 must be aborted by the reset.
        destRegAddr = 2'd3;
        srcReg2Addr = 2'd3;
        regWrite    = 1'b1;
        reset       = 1'b0;
        #1;
        n_checks++;
        if (aluResult !== 8'd0) $display("FAIL async_immediate: R0 got %0d expected 0", aluResult);
        else n_pass++;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            read_reg(i, v);
            n_checks++;
            if (v !== 8'(i)) $display("FAIL async_R%0d: got %0d expected %0d", i, v, i);
            else n_pass++;
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_op_sweep();
        test_write_enable();
        test_read_during_write();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/datapath.md
Name: datapath

Overview:
- Single-cycle register-file/ALU datapath: four general-purpose registers, two combinational read ports, one synchronous write port, and an 8-function ALU.
- Each cycle: read two source registers, combine them in the ALU, and optionally write the result to a destination register on the rising clock edge.
- Sits under the control unit, which drives addresses, opcode and write enable.

Parameters:
- DATA_W, 8, register and ALU data width in bits.
- NUM_REGS, 4, number of registers; fixed at 4 because addresses are 2 bits.

Ports:
- clk  input  1  system clock; rising edge active.
- reset  input  1  asynchronous, active-low reset (reset=0 resets).
- srcReg1Addr  input  2  address of ALU operand A (read port 1).
- srcReg2Addr  input  2  address of ALU operand B (read port 2).
- destRegAddr  input  2  write-back register address.
- aluOp  input  3  ALU function select.
- regWrite  input  1  write enable; result written at rising clk when 1.
- aluResult  output  DATA_W  combinational ALU result.

Behaviour:
- One clock; reset is asynchronous and active-low; the clock and reset ports are named clk and reset.
- Reset (reset=0, any time, independent of clk):
  - Rn is forced to the value n: R0=0, R1=1, R2=2, R3=3.
  - Registers hold these values while reset=0. Writes are ignored while reset=0.
  - Reset asserted mid-operation aborts any pending write.
- Reads are combinational: A = R[srcReg1Addr], B = R[srcReg2Addr]. Same address on both ports is legal.
- aluResult is purely combinational from A, B and aluOp: zero latency, no output register. After reset it equals f(R-init values) for the current inputs.
- Write: at a rising clk with reset=1 and regWrite=1, R[destRegAddr] <= aluResult. With regWrite=0, all registers hold.
- Read-during-write:
  - Same-cycle reads see the old value.
  - The new value appears on the read ports and aluResult just after the edge.
  - No internal bypass.
- Destination equal to a source is legal; old operand used, result stored.
- X or Z on regWrite is treated as a no-write for verification purposes; the design does not guard against it.
- ALU ops (all arithmetic modulo 2^DATA_W, unsigned, no flags):
  - 000 A+B, carry discarded.
  - 001 A-B, borrow discarded; wraps (1-2 = 0xFF).
  - 010 A AND B.
  - 011 A XOR B.
  - 100 A OR B.
  - 101 NOT A.
  - 110 SLT: 1 if A<B unsigned, else 0, zero-extended.
  - 111 pass A.
- All 8 opcodes are defined; there is no illegal-op state.

Decomposition:
- Shared package datapath_pkg:
  - DATA_W default.
  - ALU opcode constants OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_OR, OP_NOT, OP_SLT, OP_PASS.
  - Reset-value function: index to value.
- One natural sub-module: alu_unit (combinational A, B, op -> result).
- Register file stays inline in datapath.

Test Plan:
- Reset: hold reset=0 for 10 ns, then release, regWrite=0 -> R0..R3 read back 0,1,2,3. Setting src1=1, src2=2, aluOp=000 gives aluResult=3.
- Sequence with regWrite=1, one instruction per clock:
  - R0<=R1+R2 -> R0=3.
  - R1<=R2 AND R3 -> R1=2.
  - R3<=R2 XOR R0 -> R3=1.
  - R2<=R1-R3 -> R2=1.
  - Final state R0..R3 = 3,2,1,1.
- Op sweep from reset values with A=R2=2, B=R3=3, one check per opcode 000..111:
  - aluResult = 5, 0xFF, 2, 1, 3, 0xFD, 1, 2.
- Write enable: regWrite=0 with dest=0 and op ADD over several edges -> R0 unchanged at 0.
- Read-during-write: src1=dest=1, op ADD, src2=1:
  - aluResult=2 before the edge.
  - R1=2 after the edge; aluResult becomes 4 in the same cycle.
- Async reset mid-run: after writes, pull reset low between clock edges -> all registers return to 0,1,2,3 immediately, without waiting for clk.
